// File: rtl/vedic_ctrl_pkg.sv
// -----------------------------------------------------------------------------
// vedic_ctrl_pkg
// Shared definitions for the vedic multiplier arbiter: controller state
// encoding, an index-width helper and the reset values of the controller.
// -----------------------------------------------------------------------------
package vedic_ctrl_pkg;

  typedef enum logic [1:0] {
    ST_IDLE    = 2'd0,
    ST_COMPUTE = 2'd1,
    ST_RESP    = 2'd2
  } state_t;

  // Bits needed to hold an index in 0..n-1, never less than one bit.
  function automatic int idx_w(input int n);
    return (n <= 2) ? 1 : $clog2(n);
  endfunction

  localparam state_t RST_STATE      = ST_IDLE;
  localparam logic   RST_RESP_VALID = 1'b0;

endpackage : vedic_ctrl_pkg

// File: rtl/rr_pick.sv
// -----------------------------------------------------------------------------
// rr_pick
// Combinational round-robin picker: finds the first asserted request
// searching upward from i_ptr, wrapping modulo N.
//   i_valid : per-port request
//   i_ptr   : highest-priority port this cycle
//   o_grant : one-hot grant, zero when no request
//   o_idx   : encoded winner (0 when no request)
//   o_any   : at least one request present
// -----------------------------------------------------------------------------
module rr_pick #(
  parameter int N    = 4,
  parameter int ID_W = 2
) (
  input  logic [N-1:0]    i_valid,
  input  logic [ID_W-1:0] i_ptr,
  output logic [N-1:0]    o_grant,
  output logic [ID_W-1:0] o_idx,
  output logic            o_any
);

  int w_pos;

  always_comb begin
    o_grant = '0;
    o_idx   = '0;
    o_any   = 1'b0;
    w_pos   = 0;
    for (int k = 0; k < N; k++) begin
      w_pos = int'(i_ptr) + k;
      if (w_pos >= N) w_pos = w_pos - N;
      if (!o_any && i_valid[w_pos]) begin
        o_any          = 1'b1;
        o_grant[w_pos] = 1'b1;
        o_idx          = ID_W'(w_pos);
      end
    end
  end

endmodule : rr_pick

// File: rtl/signed_vedic_mult.sv
// -----------------------------------------------------------------------------
// signed_vedic_mult
// Combinational two's-complement multiplier built from 2-bit base digit
// products (Urdhva-Tiryagbhyam, vertically and crosswise), summed into a
// full-precision result. Deep logic: the caller treats it as multicycle.
//   i_a, i_b   : WIDTH-bit signed operands
//   o_product  : 2*WIDTH-bit signed product
// -----------------------------------------------------------------------------
module signed_vedic_mult #(
  parameter int WIDTH = 32
) (
  input  logic [WIDTH-1:0]   i_a,
  input  logic [WIDTH-1:0]   i_b,
  output logic [2*WIDTH-1:0] o_product
);

  // Operands are padded to an even width so every digit is two bits.
  localparam int DIGITS = (WIDTH + 1) / 2;
  localparam int EW     = 2 * DIGITS;

  logic [EW-1:0]   w_mag_a;
  logic [EW-1:0]   w_mag_b;
  logic [2*EW-1:0] w_acc;
  logic [3:0]      w_pp;
  logic            w_neg;

  // NOTE: every variable assigned in always_comb gets a default at the top of
  // the block; a path that leaves one unassigned would infer a latch.
  always_comb begin
    w_mag_a = '0;
    w_mag_b = '0;
    w_acc   = '0;
    w_pp    = '0;
    w_neg   = i_a[WIDTH-1] ^ i_b[WIDTH-1];
    // Magnitude of the most negative value wraps to itself, which read as
    // unsigned is the correct magnitude.
    w_mag_a[WIDTH-1:0] = i_a[WIDTH-1] ? -i_a : i_a;
    w_mag_b[WIDTH-1:0] = i_b[WIDTH-1] ? -i_b : i_b;
    for (int i = 0; i < DIGITS; i++) begin
      for (int j = 0; j < DIGITS; j++) begin
        w_pp  = {2'b00, w_mag_a[2*i +: 2]} * {2'b00, w_mag_b[2*j +: 2]};
        w_acc = w_acc + ({{(2*EW-4){1'b0}}, w_pp} << (2 * (i + j)));
      end
    end
    o_product = w_neg ? -w_acc[2*WIDTH-1:0] : w_acc[2*WIDTH-1:0];
  end

endmodule : signed_vedic_mult

// File: rtl/vedic_mult_arbiter.sv
// -----------------------------------------------------------------------------
// vedic_mult_arbiter
// Shares one combinational signed_vedic_mult between NUM_REQ requesters.
// A round-robin winner's operands are registered, the multiplier is given
// MC_CYCLES cycles to settle, and the product is held on one response
// channel until accepted.
//   clk, rst     : clock, asynchronous active-high reset
//   req_valid    : per-port request valid
//   req_ready    : per-port one-hot grant (IDLE only)
//   req_a, req_b : packed signed operands, port i at [i*WIDTH +: WIDTH]
//   resp_valid   : result valid (RESP state)
//   resp_ready   : downstream accepts result
//   resp_product : 2*WIDTH-bit signed product
//   resp_id      : requester that owns the result
//   busy         : state is not IDLE
// -----------------------------------------------------------------------------
module vedic_mult_arbiter
  import vedic_ctrl_pkg::*;
#(
  parameter  int WIDTH     = 32,
  parameter  int NUM_REQ   = 4,
  parameter  int MC_CYCLES = 2,
  localparam int ID_W      = idx_w(NUM_REQ)
) (
  input  logic                     clk,
  input  logic                     rst,
  input  logic [NUM_REQ-1:0]       req_valid,
  output logic [NUM_REQ-1:0]       req_ready,
  input  logic [NUM_REQ*WIDTH-1:0] req_a,
  input  logic [NUM_REQ*WIDTH-1:0] req_b,
  output logic                     resp_valid,
  input  logic                     resp_ready,
  output logic [2*WIDTH-1:0]       resp_product,
  output logic [ID_W-1:0]          resp_id,
  output logic                     busy
);

  localparam int CNT_W = idx_w(MC_CYCLES);

  state_t             r_state;
  logic [ID_W-1:0]    r_rr_ptr;
  logic [CNT_W-1:0]   r_cnt;
  logic [WIDTH-1:0]   r_a;
  logic [WIDTH-1:0]   r_b;
  logic [ID_W-1:0]    r_id;
  logic [2*WIDTH-1:0] r_product;

  logic [NUM_REQ-1:0] w_grant;
  logic [ID_W-1:0]    w_win;
  logic               w_any;
  logic [ID_W-1:0]    w_ptr_next;
  logic [WIDTH-1:0]   w_a_sel;
  logic [WIDTH-1:0]   w_b_sel;
  logic [2*WIDTH-1:0] w_product;

  rr_pick #(
    .N    (NUM_REQ),
    .ID_W (ID_W)
  ) u_rr_pick (
    .i_valid (req_valid),
    .i_ptr   (r_rr_ptr),
    .o_grant (w_grant),
    .o_idx   (w_win),
    .o_any   (w_any)
  );

  // Only the registered operands feed the multiplier, so its inputs are
  // stable for the whole multicycle window.
  signed_vedic_mult #(
    .WIDTH (WIDTH)
  ) u_mult (
    .i_a       (r_a),
    .i_b       (r_b),
    .o_product (w_product)
  );

  assign w_a_sel    = req_a[w_win*WIDTH +: WIDTH];
  assign w_b_sel    = req_b[w_win*WIDTH +: WIDTH];
  assign w_ptr_next = (w_win == ID_W'(NUM_REQ - 1)) ? '0 : w_win + ID_W'(1);

  // Grant is suppressed while reset is held so no transfer can be seen by a
  // requester that the controller will not register.
  assign req_ready    = (r_state == ST_IDLE && !rst) ? w_grant : '0;
  assign resp_valid   = (r_state == ST_RESP);
  assign busy         = (r_state != ST_IDLE);
  assign resp_product = r_product;
  assign resp_id      = r_id;

  // NOTE: state registers use non-blocking assignments so every register
  // samples pre-edge values; blocking here would create order-dependent races.
  // NOTE: the operand/result registers are small and explicitly reset so a
  // discarded operation leaves nothing visible on resp_product/resp_id.
  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      r_state   <= RST_STATE;
      r_rr_ptr  <= '0;
      r_cnt     <= '0;
      r_a       <= '0;
      r_b       <= '0;
      r_id      <= '0;
      r_product <= '0;
    end else begin
      case (r_state)
        ST_IDLE: begin
          if (w_any) begin
            r_a      <= w_a_sel;
            r_b      <= w_b_sel;
            r_id     <= w_win;
            r_rr_ptr <= w_ptr_next;
            r_cnt    <= CNT_W'(MC_CYCLES - 1);
            r_state  <= ST_COMPUTE;
          end
        end
        ST_COMPUTE: begin
          if (r_cnt == '0) begin
            r_product <= w_product;
            r_state   <= ST_RESP;
          end else begin
            r_cnt <= r_cnt - CNT_W'(1);
          end
        end
        ST_RESP: begin
          if (resp_ready) r_state <= ST_IDLE;
        end
        default: r_state <= ST_IDLE;
      endcase
    end
  end

endmodule : vedic_mult_arbiter

// File: tb/tb_vedic_mult_arbiter.sv
// -----------------------------------------------------------------------------
// tb_vedic_mult_arbiter
// Directed bench for vedic_mult_arbiter (WIDTH=32, NUM_REQ=4, MC_CYCLES=2).
// Inputs change and outputs are sampled 2-3 time units after a rising edge.
// -----------------------------------------------------------------------------
module tb_vedic_mult_arbiter;

  localparam int WIDTH = 32;
  localparam int NREQ  = 4;

  logic               clk;
  logic               rst;
  logic [NREQ-1:0]    req_valid;
  logic [NREQ-1:0]    req_ready;
  logic [NREQ*32-1:0] req_a;
  logic [NREQ*32-1:0] req_b;
  logic               resp_valid;
  logic               resp_ready;
  logic [63:0]        resp_product;
  logic [1:0]         resp_id;
  logic               busy;

  int n_cmp  = 0;
  int n_bad  = 0;
  int n_resp = 0;
  int cyc    = 0;
  bit watch13 = 0;
  bit bad13   = 0;

  vedic_mult_arbiter #(
    .WIDTH     (WIDTH),
    .NUM_REQ   (NREQ),
    .MC_CYCLES (2)
  ) dut (
    .clk          (clk),
    .rst          (rst),
    .req_valid    (req_valid),
    .req_ready    (req_ready),
    .req_a        (req_a),
    .req_b        (req_b),
    .resp_valid   (resp_valid),
    .resp_ready   (resp_ready),
    .resp_product (resp_product),
    .resp_id      (resp_id),
    .busy         (busy)
  );

  initial clk = 1'b0;
  always #5 clk = ~clk;

  // Counts completed response handshakes.
  always @(posedge clk) begin
    if (!rst && resp_valid && resp_ready) n_resp <= n_resp + 1;
  end

  initial begin
    #200000;
    $display("FAIL watchdog: simulation did not finish in time");
    $fatal(1, "watchdog expired");
  end

  task automatic check(input string tag, input logic [127:0] obs, input logic [127:0] exp);
    n_cmp++;
    assert (obs === exp) else begin
      n_bad++;
      $error("FAIL %s: observed=%0h expected=%0h", tag, obs, exp);
    end
  endtask

  task automatic step();
    @(posedge clk);
    #2;
    cyc++;
    if (watch13 && (req_ready[1] || req_ready[3])) bad13 = 1'b1;
  endtask

  task automatic do_reset();
    rst = 1'b1;
    step();
    step();
    rst = 1'b0;
    #1;
  endtask

  task automatic set_port(input int p, input logic [31:0] a, input logic [31:0] b, input logic v);
    req_a[p*32 +: 32] = a;
    req_b[p*32 +: 32] = b;
    req_valid[p]      = v;
  endtask

  task automatic wait_grant(input string tag, output int port);
    bit ok;
    ok   = 1'b0;
    port = -1;
    for (int t = 0; t < 20; t++) begin
      #1;
      if (req_ready != '0) begin
        ok = 1'b1;
        break;
      end
      step();
    end
    check({tag, " grant seen"}, ok, 1);
    if (ok) begin
      check({tag, " grant one-hot"}, $onehot(req_ready), 1);
      for (int i = 0; i < NREQ; i++) if (req_ready[i]) port = i;
    end
  endtask

  // One isolated operation on one port: grant, latency, product, id, release.
  task automatic do_single(input string tag, input int p, input logic [31:0] a,
                           input logic [31:0] b, input logic [63:0] exp);
    int port;
    int t;
    bit hit;
    resp_ready = 1'b0;
    set_port(p, a, b, 1'b1);
    wait_grant(tag, port);
    check({tag, " port"}, port, p);
    step();
    req_valid[p] = 1'b0;
    resp_ready   = 1'b1;
    hit = 1'b0;
    for (t = 1; t < 20; t++) begin
      #1;
      if (resp_valid) begin
        hit = 1'b1;
        break;
      end
      step();
    end
    check({tag, " resp seen"}, hit, 1);
    check({tag, " latency"}, t, 3);
    check({tag, " product"}, resp_product, exp);
    check({tag, " id"}, resp_id, p);
    step();
    #1;
    check({tag, " released"}, {resp_valid, busy}, 2'b00);
  endtask

  int port;
  int g_prev;
  int n0;
  bit seen;
  logic [63:0] exp2 [4];

  initial begin
    rst        = 1'b1;
    req_valid  = '0;
    req_a      = '0;
    req_b      = '0;
    resp_ready = 1'b0;

    // Reset state
    step();
    #1;
    check("reset busy", busy, 0);
    check("reset resp_valid", resp_valid, 0);
    check("reset req_ready", req_ready, 0);
    check("reset product", resp_product, 0);
    check("reset id", resp_id, 0);
    rst = 1'b0;
    step();

    // Single request on port 0: -2 * 3
    set_port(0, 32'hFFFF_FFFE, 32'h0000_0003, 1'b1);
    resp_ready = 1'b1;
    #1;
    check("t1 grant", req_ready, 4'b0001);
    check("t1 busy at T", busy, 0);
    step();
    req_valid[0] = 1'b0;
    #1;
    check("t1 busy T+1", {busy, resp_valid}, 2'b10);
    step();
    #1;
    check("t1 busy T+2", {busy, resp_valid}, 2'b10);
    step();
    #1;
    check("t1 valid T+3", {busy, resp_valid}, 2'b11);
    check("t1 product", resp_product, 64'hFFFF_FFFF_FFFF_FFFA);
    check("t1 id", resp_id, 0);
    step();
    #1;
    check("t1 idle after accept", {busy, resp_valid}, 2'b00);

    // All four ports valid together, resp_ready tied high
    do_reset();
    exp2 = '{64'd6, 64'hFFFF_FFFF_FFFF_FFFA, 64'hFFFF_FFFF_FFFF_FFFA, 64'd6};
    set_port(0, 32'd2, 32'd3, 1'b1);
    set_port(1, 32'hFFFF_FFFE, 32'd3, 1'b1);
    set_port(2, 32'd2, 32'hFFFF_FFFD, 1'b1);
    set_port(3, 32'hFFFF_FFFE, 32'hFFFF_FFFD, 1'b1);
    resp_ready = 1'b1;
    g_prev = 0;
    for (int k = 0; k < 4; k++) begin
      wait_grant("t2", port);
      check("t2 order", port, k);
      if (k > 0) check("t2 interval", cyc - g_prev, 4);
      g_prev = cyc;
      step();
      if (port >= 0) req_valid[port] = 1'b0;
      step();
      step();
      #1;
      check("t2 resp_valid", resp_valid, 1);
      check("t2 product", resp_product, exp2[k]);
      check("t2 id", resp_id, k);
      step();
    end

    // Ports 0 and 2 continuously valid
    do_reset();
    set_port(0, 32'd4, 32'd5, 1'b1);
    set_port(2, 32'hFFFF_FFFF, 32'd9, 1'b1);
    resp_ready = 1'b1;
    bad13   = 1'b0;
    watch13 = 1'b1;
    for (int k = 0; k < 4; k++) begin
      wait_grant("t3", port);
      check("t3 alternation", port, (k % 2) * 2);
      step();
      step();
      step();
      #1;
      check("t3 resp_valid", resp_valid, 1);
      check("t3 product", resp_product, (k % 2 == 0) ? 64'd20 : 64'hFFFF_FFFF_FFFF_FFF7);
      step();
    end
    watch13 = 1'b0;
    check("t3 no grant to 1/3", bad13, 0);
    req_valid = '0;

    // Backpressure
    do_reset();
    set_port(0, 32'd5, 32'd7, 1'b1);
    set_port(1, 32'hFFFF_FFFC, 32'd8, 1'b1);
    resp_ready = 1'b0;
    wait_grant("t4", port);
    check("t4 first port", port, 0);
    step();
    req_valid[0] = 1'b0;
    step();
    step();
    #1;
    check("t4 resp_valid", resp_valid, 1);
    n0 = n_resp;
    for (int i = 0; i < 5; i++) begin
      step();
      #1;
      check("t4 hold valid", resp_valid, 1);
      check("t4 hold product", resp_product, 64'd35);
      check("t4 hold id", resp_id, 0);
      check("t4 hold no grant", req_ready, 0);
    end
    resp_ready = 1'b1;
    step();
    resp_ready = 1'b0;
    #1;
    check("t4 one response", n_resp, n0 + 1);
    check("t4 next grant", req_ready, 4'b0010);
    step();
    req_valid[1] = 1'b0;
    step();
    step();
    step();
    step();
    #1;
    check("t4 still one response", n_resp, n0 + 1);
    check("t4 port1 waiting", {resp_valid, resp_id}, {1'b1, 2'd1});
    check("t4 port1 product", resp_product, 64'hFFFF_FFFF_FFFF_FFE0);

    // Extremes
    do_reset();
    do_single("t5 min*min", 1, 32'h8000_0000, 32'h8000_0000, 64'h4000_0000_0000_0000);
    do_single("t5 min*-1", 2, 32'h8000_0000, 32'hFFFF_FFFF, 64'h0000_0000_8000_0000);
    do_single("t5 max*max", 0, 32'h7FFF_FFFF, 32'h7FFF_FFFF, 64'h3FFF_FFFF_0000_0001);

    // Reset during COMPUTE
    resp_ready = 1'b0;
    set_port(3, 32'd3, 32'd3, 1'b1);
    wait_grant("t6", port);
    check("t6 port", port, 3);
    step();
    req_valid[3] = 1'b0;
    #1;
    check("t6 in compute", busy, 1);
    rst = 1'b1;
    #1;
    check("t6 busy cleared", busy, 0);
    check("t6 resp_valid cleared", resp_valid, 0);
    check("t6 product cleared", resp_product, 0);
    check("t6 id cleared", resp_id, 0);
    req_valid[2] = 1'b1;
    #1;
    check("t6 no grant in reset", req_ready, 0);
    req_valid[2] = 1'b0;
    resp_ready   = 1'b1;
    step();
    step();
    rst  = 1'b0;
    n0   = n_resp;
    seen = 1'b0;
    for (int i = 0; i < 6; i++) begin
      step();
      #1;
      if (resp_valid) seen = 1'b1;
    end
    check("t6 no stale resp_valid", seen, 0);
    check("t6 no stale response", n_resp, n0);
    set_port(0, 32'd1, 32'd1, 1'b1);
    set_port(2, 32'd1, 32'd1, 1'b1);
    #1;
    check("t6 port 0 first", req_ready, 4'b0001);
    req_valid = '0;

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule : tb_vedic_mult_arbiter
